stack_arbiter_2ch: RTL and testbench
====================================

Name: stack_arbiter_2ch

Overview:
- Two-requester round-robin arbiter and sequencer in front of a single stack_8x8 instance (8 entries × 8 bits, cmd 00 nop / 01 clear / 10 push / 11 pop).
- Serialises clear/push/pop transactions from two clients, drives the stack cmd/data for exactly one cycle, waits out the stack's flag latency and returns a per-client response.
- Sits between client logic and the stack; the stack itself is instantiated outside this block.

Parameters:
- DW, 8, data width of the stack words.
- RSP_LAT, 2, number of idle cycles between the command cycle and the response capture. Legal range 1-7.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  client 0 request. Held with cmd0/din0 stable until gnt0.
- cmd0  in  2  client 0 command (01 clear, 10 push, 11 pop).
- din0  in  DW  client 0 push data.
- gnt0  out  1  one-cycle pulse when client 0's request is accepted.
- rsp_vld0  out  1  one-cycle pulse when client 0's response is valid.
- req1, cmd1, din1, gnt1, rsp_vld1: as the client 0 ports, for client 1.
- rsp_data  out  DW  pop data, shared by both clients, valid with rsp_vld0 or rsp_vld1.
- rsp_err  out  1  error status, valid with rsp_vld*.
- busy  out  1  high in every state except IDLE.
- stk_cmd  out  2  command to the stack.
- stk_din  out  DW  push data to the stack.
- stk_dout  in  DW  stack data_out.
- stk_full  in  1  stack full flag.
- stk_empty  in  1  stack empty flag.
- stk_error  in  1  stack error flag.

Behaviour:
- Reset values (asynchronous): state IDLE, all outputs 0, stk_cmd 00, rr_last 1 (client 0 wins the first tie).
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - A request qualifies when req=1 and cmd≠00.
  - A request with cmd=00 is never granted.
  - One qualifying client: grant it.
  - Both qualifying: grant the client ≠ rr_last.
  - On grant: pulse gnt for this cycle; latch owner, cmd and din; set rr_last to owner; go to ISSUE.
- ISSUE: stk_cmd = latched cmd and stk_din = latched din for exactly one cycle; go to WAIT with the wait counter at 0.
- WAIT:
  - stk_cmd = 00.
  - Counter increments each cycle; leave for RESP when it reaches RSP_LAT-1, so WAIT lasts RSP_LAT cycles.
- RESP:
  - Capture stk_dout into rsp_data for pops only; rsp_data holds its previous value for clear and push.
  - Capture stk_error into rsp_err.
  - Pulse the owner's rsp_vld.
  - Return to IDLE. A new grant is possible in the next cycle, not in the RESP cycle itself.
- Throughput: one transaction per RSP_LAT+3 cycles (grant, ISSUE, WAIT×RSP_LAT, RESP).
- stk_cmd is non-00 only in ISSUE; it is never held for two cycles.
- Request edge cases:
  - A request withdrawn before its grant is simply dropped.
  - Requests arriving while busy are not granted; the client keeps req high.
- Reset mid-transaction: FSM returns to IDLE and stk_cmd goes to 00 immediately. No response is issued. Stack contents are not restored.
- rsp_data and rsp_err hold their values between responses.

Optional Feature:
- Macro STACK_ARB_PRECHECK_EN.
- Defined:
  - In IDLE at grant time, a push with stk_full=1, or a pop with stk_empty=1, is rejected locally.
  - A rejected request is granted normally, then goes straight to RESP with rsp_err=1 and rsp_data unchanged, skipping ISSUE and WAIT.
  - No command reaches the stack for a rejected request.
- Undefined: every granted request is issued to the stack, and errors come from stk_error.

Decomposition:
- Package stack_arb_pkg holds:
  - command constants CMD_NOP=2'b00, CMD_CLR=2'b01, CMD_PUSH=2'b10, CMD_POP=2'b11;
  - FSM state encoding ST_IDLE/ST_ISSUE/ST_WAIT/ST_RESP;
  - DW default.
- One natural sub-module: rr_arb2, the two-way round-robin pick with rr_last state, enabled only in IDLE.

Test Plan:
- Reset, then req0 push 8'hA5 alone: gnt0 at cycle 0, stk_cmd=10 and stk_din=A5 at cycle 1; with RSP_LAT=2, rsp_vld0=1, rsp_err=0 at cycle 4.
- Push 8 values 1..8 from client 0, then a 9th push: 9th response rsp_err=1. With STACK_ARB_PRECHECK_EN, the 9th stk_cmd stays 00 throughout.
- Both clients request continuously: grants alternate 0,1,0,1 starting with client 0, and each grant is spaced exactly 5 cycles apart.
- After clear, pop from client 1: rsp_vld1=1 with rsp_err=1, rsp_data unchanged from its previous value.
- Push 3C, push 7E, pop, pop: rsp_data matches stk_dout sampled in each RESP cycle, and rsp_err=0 for all four transactions.
- Assert rst_n low during WAIT: busy=0, stk_cmd=00, no rsp_vld pulse. After release, a fresh req1 is granted.

Source files
------------

// File: rtl/stack_arb_pkg.sv
// Shared constants for the two-client stack arbiter.
// Optional local precheck: STACK_ARB_PRECHECK_EN.
package stack_arb_pkg;

  localparam int DW_DEF = 8;

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_CLR  = 2'b01;
  localparam logic [1:0] CMD_PUSH = 2'b10;
  localparam logic [1:0] CMD_POP  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/stack_arbiter_2ch_rr_arb2.sv
// Two-way round-robin pick; rr_last names the most recent winner.
// Reset favours client 0 on the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic rr_last;

  always_comb begin
    gnt[0] = en & req[0] & (~req[1] | rr_last);
    gnt[1] = en & req[1] & (~req[0] | ~rr_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= 1'b1;
    end else if (|gnt) begin
      rr_last <= gnt[1];
    end
  end

endmodule

// File: rtl/stack_arbiter_2ch.sv
// Serialises clear/push/pop from two clients onto one stack_8x8.
// Define STACK_ARB_PRECHECK_EN to reject push-full/pop-empty locally.
module stack_arbiter_2ch
  import stack_arb_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int RSP_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [1:0]    cmd0,
  input  logic [DW-1:0] din0,
  output logic          gnt0,
  output logic          rsp_vld0,
  input  logic          req1,
  input  logic [1:0]    cmd1,
  input  logic [DW-1:0] din1,
  output logic          gnt1,
  output logic          rsp_vld1,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          busy,
  output logic [1:0]    stk_cmd,
  output logic [DW-1:0] stk_din,
  input  logic [DW-1:0] stk_dout,
  input  logic          stk_full,
  input  logic          stk_empty,
  input  logic          stk_error
);

  localparam int CW = 3;
  localparam logic [CW-1:0] CNT_END = CW'(RSP_LAT - 1);

  state_t          state;
  logic            owner;
  logic [1:0]      cmd_q;
  logic [CW-1:0]   cnt;
  logic [1:0]      qual;
  logic [1:0]      gnt;
  logic [1:0]      sel_cmd;
  logic [DW-1:0]   sel_din;
  logic            reject;

  assign qual[0] = req0 & (cmd0 != CMD_NOP);
  assign qual[1] = req1 & (cmd1 != CMD_NOP);

  rr_arb2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == ST_IDLE),
    .req   (qual),
    .gnt   (gnt)
  );

  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];
  assign sel_cmd = gnt[1] ? cmd1 : cmd0;
  assign sel_din = gnt[1] ? din1 : din0;
  assign busy    = (state != ST_IDLE);

`ifdef STACK_ARB_PRECHECK_EN
  assign reject = ((sel_cmd == CMD_PUSH) && stk_full) ||
                  ((sel_cmd == CMD_POP) && stk_empty);
`else
  logic unused_flags;
  assign unused_flags = stk_full ^ stk_empty;
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      owner    <= 1'b0;
      cmd_q    <= CMD_NOP;
      cnt      <= '0;
      stk_cmd  <= CMD_NOP;
      stk_din  <= '0;
      rsp_vld0 <= 1'b0;
      rsp_vld1 <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (|gnt) begin
            owner   <= gnt[1];
            cmd_q   <= sel_cmd;
            stk_din <= sel_din;
            if (reject) begin
              // rejected locally: answer without touching the stack
              state    <= ST_RESP;
              rsp_err  <= 1'b1;
              rsp_vld0 <= ~gnt[1];
              rsp_vld1 <= gnt[1];
            end else begin
              state   <= ST_ISSUE;
              stk_cmd <= sel_cmd;
            end
          end
        end
        ST_ISSUE: begin
          stk_cmd <= CMD_NOP;
          cnt     <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == CNT_END) begin
            state    <= ST_RESP;
            rsp_err  <= stk_error;
            rsp_vld0 <= ~owner;
            rsp_vld1 <= owner;
            if (cmd_q == CMD_POP) begin
              rsp_data <= stk_dout;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          rsp_vld0 <= 1'b0;
          rsp_vld1 <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_arbiter_2ch.sv
// Directed bench for stack_arbiter_2ch with a behavioural 8x8 stack.
// Honours STACK_ARB_PRECHECK_EN when the design is built with it.
module tb_stack_arbiter_2ch;
  import stack_arb_pkg::*;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [1:0]    cmd0 = 2'b00, cmd1 = 2'b00;
  logic [DW-1:0] din0 = '0, din1 = '0;
  logic          gnt0, gnt1, rsp_vld0, rsp_vld1;
  logic [DW-1:0] rsp_data;
  logic          rsp_err, busy;
  logic [1:0]    stk_cmd;
  logic [DW-1:0] stk_din, stk_dout;
  logic          stk_full, stk_empty, stk_error;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stack_arbiter_2ch #(.DW(DW), .RSP_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .cmd0(cmd0), .din0(din0),
    .gnt0(gnt0), .rsp_vld0(rsp_vld0),
    .req1(req1), .cmd1(cmd1), .din1(din1),
    .gnt1(gnt1), .rsp_vld1(rsp_vld1),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .stk_cmd(stk_cmd), .stk_din(stk_din), .stk_dout(stk_dout),
    .stk_full(stk_full), .stk_empty(stk_empty),
    .stk_error(stk_error)
  );

  // behavioural stack: acts on the edge ending the command cycle
  logic [DW-1:0] mem [8];
  int            sp = 0;
  logic [DW-1:0] s_dout = '0;
  logic          s_err = 1'b0;

  always @(posedge clk) begin
    case (stk_cmd)
      CMD_CLR: begin sp <= 0; s_err <= 1'b0; end
      CMD_PUSH:
        if (sp == 8) s_err <= 1'b1;
        else begin
          mem[sp] <= stk_din; sp <= sp + 1; s_err <= 1'b0;
        end
      CMD_POP:
        if (sp == 0) s_err <= 1'b1;
        else begin
          s_dout <= mem[sp-1]; sp <= sp - 1; s_err <= 1'b0;
        end
      default: ;
    endcase
  end

  assign stk_full  = (sp == 8);
  assign stk_empty = (sp == 0);
  assign stk_dout  = s_dout;
  assign stk_error = s_err;

  int issued = 0, held = 0, vld_cnt = 0;
  logic [1:0] prev_cmd = 2'b00;

  always @(posedge clk) begin
    if (stk_cmd != CMD_NOP) issued++;
    if (stk_cmd != CMD_NOP && prev_cmd != CMD_NOP) held++;
    prev_cmd = stk_cmd;
    if (rsp_vld0 || rsp_vld1) vld_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input int c, input logic [1:0] cmd,
                     input logic [7:0] d, input logic exp_err,
                     input logic chk_d, input logic [7:0] exp_d,
                     input string tag);
    int n;
    @(posedge clk); #1;
    if (c == 0) begin req0 = 1; cmd0 = cmd; din0 = d; end
    else begin req1 = 1; cmd1 = cmd; din1 = d; end
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if ((c == 0) ? gnt0 : gnt1) break;
    end
    chk($sformatf("%s gnt", tag), 32'(n < 20), 1);
    @(posedge clk); #1;
    if (c == 0) req0 = 0; else req1 = 0;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if ((c == 0) ? rsp_vld0 : rsp_vld1) break;
    end
    chk($sformatf("%s rsp", tag), 32'(n < 20), 1);
    chk($sformatf("%s err", tag), 32'(rsp_err), 32'(exp_err));
    if (chk_d) chk($sformatf("%s data", tag), 32'(rsp_data), 32'(exp_d));
  endtask

  initial begin
    int base;
    int g_cyc [4];
    int g_own [4];
    int ng, both, n;

    repeat (2) @(negedge clk);
    chk("reset outs",
        {gnt0, gnt1, rsp_vld0, rsp_vld1, rsp_err, busy, stk_cmd,
         rsp_data, stk_din}, 0);
    @(posedge clk); #1; rst_n = 1;

    // single push, cycle exact
    @(posedge clk); #1;
    req0 = 1; cmd0 = CMD_PUSH; din0 = 8'hA5;
    @(negedge clk);
    chk("c0 gnt", {gnt0, gnt1, stk_cmd}, 32'b1000);
    @(posedge clk); #1; req0 = 0;
    @(negedge clk);
    chk("c1 issue", {busy, stk_cmd, stk_din}, {21'd0, 1'b1, 2'b10, 8'hA5});
    @(negedge clk);
    chk("c2 cmd nop", 32'(stk_cmd), 0);
    @(negedge clk);
    chk("c3 no rsp", {rsp_vld0, rsp_vld1}, 0);
    @(negedge clk);
    chk("c4 rsp", {rsp_vld0, rsp_vld1, rsp_err}, 32'b100);
    @(negedge clk);
    chk("c5 idle", {rsp_vld0, busy}, 0);

    // nop request must never be granted
    @(posedge clk); #1; req0 = 1; cmd0 = CMD_NOP;
    n = 0;
    repeat (3) begin @(negedge clk); if (gnt0 || busy) n++; end
    chk("nop not granted", n, 0);
    @(posedge clk); #1; req0 = 0;

    // fill to full then overflow
    txn(0, CMD_CLR, 8'h00, 1'b0, 1'b0, 8'h00, "clr");
    for (int i = 1; i <= 8; i++)
      txn(0, CMD_PUSH, 8'(i), 1'b0, 1'b0, 8'h00, $sformatf("push%0d", i));
    base = issued;
    txn(0, CMD_PUSH, 8'h09, 1'b1, 1'b0, 8'h00, "push9");
`ifdef STACK_ARB_PRECHECK_EN
    chk("push9 issued", issued - base, 0);
`else
    chk("push9 issued", issued - base, 1);
`endif
    txn(0, CMD_POP, 8'h00, 1'b0, 1'b1, 8'h08, "pop full");

    // pop after clear from client 1: error, data held at 08
    txn(1, CMD_CLR, 8'h00, 1'b0, 1'b0, 8'h00, "clr1");
    txn(1, CMD_POP, 8'h00, 1'b1, 1'b1, 8'h08, "pop empty");

    // LIFO order across both clients
    txn(0, CMD_PUSH, 8'h3C, 1'b0, 1'b0, 8'h00, "push 3C");
    txn(1, CMD_PUSH, 8'h7E, 1'b0, 1'b0, 8'h00, "push 7E");
    txn(0, CMD_POP, 8'h00, 1'b0, 1'b1, 8'h7E, "pop 7E");
    txn(1, CMD_POP, 8'h00, 1'b0, 1'b1, 8'h3C, "pop 3C");

    // continuous contention after reset
    @(posedge clk); #1; rst_n = 0;
    @(negedge clk);
    chk("rst busy", {busy, rsp_data}, 0);
    @(posedge clk); #1; rst_n = 1;
    req0 = 1; cmd0 = CMD_CLR; req1 = 1; cmd1 = CMD_CLR;
    ng = 0; both = 0;
    for (int cyc = 0; cyc < 18; cyc++) begin
      @(negedge clk);
      if (gnt0 && gnt1) both++;
      if ((gnt0 || gnt1) && ng < 4) begin
        g_cyc[ng] = cyc; g_own[ng] = gnt1 ? 1 : 0; ng++;
      end
    end
    @(posedge clk); #1; req0 = 0; req1 = 0;
    chk("rr count", ng, 4);
    chk("rr both", both, 0);
    for (int k = 0; k < ng; k++) begin
      chk($sformatf("rr own%0d", k), g_own[k], k % 2);
      chk($sformatf("rr cyc%0d", k), g_cyc[k], 5 * k);
    end
    for (n = 0; n < 20 && busy; n++) @(negedge clk);
    chk("rr drain", 32'(busy), 0);

    // reset during WAIT
    @(posedge clk); #1; req1 = 1; cmd1 = CMD_PUSH; din1 = 8'h55;
    @(negedge clk);
    chk("mid gnt1", 32'(gnt1), 1);
    @(posedge clk); #1; req1 = 0;
    @(posedge clk); #1;
    chk("mid wait busy", {busy, stk_cmd}, 32'b100);
    base = vld_cnt;
    rst_n = 0; #1;
    chk("mid rst", {busy, stk_cmd, rsp_vld0, rsp_vld1}, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1; rst_n = 1;
    repeat (8) @(negedge clk);
    chk("mid no rsp", vld_cnt - base, 0);
    txn(1, CMD_CLR, 8'h00, 1'b0, 1'b0, 8'h00, "post rst");

    chk("cmd held", held, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
